// File: rtl/mem_stage_pkg.sv
// Shared types and sizing helpers for the SRAM-backed MEM stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

  // Wait-state counter width; covers WAIT_CYCLES up to 15.
  localparam int unsigned WAIT_CNT_W = 4;

  function automatic int unsigned beats_of(input int unsigned dw);
    return 32 / dw;
  endfunction

  function automatic int unsigned log2_of(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned beat_w_of(input int unsigned dw);
    return (beats_of(dw) > 1) ? log2_of(beats_of(dw)) : 1;
  endfunction

endpackage

// File: rtl/sram_beat_seq.sv
// Wait-state and beat sequencer for multi-beat accesses to an asynchronous SRAM.
module sram_beat_seq
  import mem_stage_pkg::*;
#(
  parameter int unsigned BEAT_W      = 1,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BEAT_W-1:0] first_beat,
  input  logic [BEAT_W-1:0] last_idx,
  input  logic              active,
  output logic [BEAT_W-1:0] beat,
  output logic              beat_done,
  output logic              last_beat
);

  logic [WAIT_CNT_W-1:0] wcnt;
  logic [BEAT_W-1:0]     last_q;

  assign beat_done = active && (wcnt == WAIT_CNT_W'(WAIT_CYCLES));
  assign last_beat = beat_done && (beat == last_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat   <= '0;
      wcnt   <= '0;
      last_q <= '0;
    end else if (start) begin
      beat   <= first_beat;
      wcnt   <= '0;
      last_q <= last_idx;
    end else if (beat_done) begin
      wcnt <= '0;
      if (!last_beat) beat <= beat + 1'b1;
    end else if (active) begin
      wcnt <= wcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// Pipeline MEM stage driving an asynchronous SRAM directly, stalling via freeze.
// Optional byte/half accesses are enabled by defining SUBWORD_ACCESS_EN.
module mem_stage_sram
  import mem_stage_pkg::*;
#(
  parameter int unsigned SRAM_DW     = 16,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_val,
  input  logic               MEM_R_en,
  input  logic               MEM_W_en,
`ifdef SUBWORD_ACCESS_EN
  input  logic [1:0]         MEM_size,
  input  logic               MEM_signed,
`endif
  output logic [31:0]        MEM_R_value,
  output logic               freeze,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int unsigned BEATS  = beats_of(SRAM_DW);
  localparam int unsigned LOG_B  = log2_of(BEATS);
  localparam int unsigned BEAT_W = beat_w_of(SRAM_DW);
  localparam int unsigned IDX_W  = SRAM_AW - LOG_B;

  state_t              state_q, state_d;
  logic                req, start, wr_q;
  logic [IDX_W-1:0]    widx_q;
  logic [31:0]         wdata_q, rbuf_q, rword, st_data, r_fmt;
  logic [SRAM_DW-1:0]  wslice;
  logic [BEAT_W-1:0]   beat, first_beat, last_idx;
  logic                beat_done, last_beat;

  assign req    = MEM_R_en | MEM_W_en;
  assign start  = (state_q == IDLE) && req;
  assign freeze = req && (state_q != DONE);

`ifdef SUBWORD_ACCESS_EN
  localparam int unsigned BPB = SRAM_DW / 8;

  logic [1:0]  size_q, ofs_q;
  logic        signed_q;
  logic [31:0] shifted;
  int unsigned nbytes, nbeats, fb;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^ALU_result[31:IDX_W+2];

  // Only the beats covering the addressed bytes are issued.
  always_comb begin
    nbytes     = (MEM_size == SIZE_BYTE) ? 1 : (MEM_size == SIZE_HALF) ? 2 : 4;
    nbeats     = (nbytes > BPB) ? nbytes / BPB : 1;
    fb         = 32'(ALU_result[1:0]) / BPB;
    first_beat = BEAT_W'(fb);
    last_idx   = BEAT_W'(fb + nbeats - 1);
    case (MEM_size)
      SIZE_BYTE: st_data = {4{ST_val[7:0]}};
      SIZE_HALF: st_data = {2{ST_val[15:0]}};
      default:   st_data = ST_val;
    endcase
  end

  always_comb begin
    shifted = rword >> {ofs_q, 3'b000};
    case (size_q)
      SIZE_BYTE: r_fmt = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: r_fmt = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default:   r_fmt = shifted;
    endcase
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{ALU_result[31:IDX_W+2], ALU_result[1:0]};
  assign first_beat       = '0;
  assign last_idx         = BEAT_W'(BEATS - 1);
  assign st_data          = ST_val;
  assign r_fmt            = rword;
`endif

  sram_beat_seq #(
    .BEAT_W      (BEAT_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_beat (first_beat),
    .last_idx   (last_idx),
    .active     (state_q == ACCESS),
    .beat       (beat),
    .beat_done  (beat_done),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b0;
    SRAM_LB_N = 1'b0;
    case (state_q)
      IDLE: if (req) state_d = ACCESS;
      ACCESS: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = wr_q;
        SRAM_WE_N = !wr_q;
`ifdef SUBWORD_ACCESS_EN
        if (SRAM_DW >= 16 && size_q == SIZE_BYTE) begin
          SRAM_UB_N = !ofs_q[0];
          SRAM_LB_N = ofs_q[0];
        end
`endif
        if (last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store wins when both requests are raised together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
`ifdef SUBWORD_ACCESS_EN
      size_q   <= SIZE_WORD;
      ofs_q    <= '0;
      signed_q <= 1'b0;
`endif
    end else if (start) begin
      wr_q     <= MEM_W_en;
      widx_q   <= ALU_result[IDX_W+1:2];
      wdata_q  <= st_data;
`ifdef SUBWORD_ACCESS_EN
      size_q   <= MEM_size;
      ofs_q    <= ALU_result[1:0];
      signed_q <= MEM_signed;
`endif
    end
  end

  generate
    if (BEATS == 1) begin : g_addr_word
      assign SRAM_ADDR = widx_q;
    end else begin : g_addr_beat
      assign SRAM_ADDR = {widx_q, beat};
    end
  endgenerate

  assign wslice  = wdata_q[SRAM_DW*32'(beat) +: SRAM_DW];
  assign SRAM_DQ = ((state_q == ACCESS) && wr_q) ? wslice : {SRAM_DW{1'bz}};

  always_comb begin
    rword = rbuf_q;
    rword[SRAM_DW*32'(beat) +: SRAM_DW] = SRAM_DQ;
  end

  // NOTE: the read buffer is a flop bank, not a RAM array, so it takes the
  // asynchronous reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbuf_q      <= '0;
      MEM_R_value <= '0;
    end else if (beat_done && !wr_q) begin
      rbuf_q <= rword;
      if (last_beat) MEM_R_value <= r_fmt;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Randomized self-checking bench for mem_stage_sram against an SRAM model and word-level reference.
module tb_mem_stage_sram;

  localparam int DW    = 16;
  localparam int AW    = 18;
  localparam int WC    = 1;
  localparam int BEATS = 32 / DW;
  localparam int LOG_B = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-configuration DUT
  logic [31:0]   alu, st_val;
  logic          r_en, w_en;
  wire  [31:0]   r_value;
  wire           freeze;
  wire  [DW-1:0] dq;
  wire  [AW-1:0] addr;
  wire           ub_n, lb_n, we_n, ce_n, oe_n;
`ifdef SUBWORD_ACCESS_EN
  logic [1:0]    size;
  logic          sgn;
`endif

  mem_stage_sram #(.SRAM_DW(DW), .SRAM_AW(AW), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst(rst), .ALU_result(alu), .ST_val(st_val),
    .MEM_R_en(r_en), .MEM_W_en(w_en),
`ifdef SUBWORD_ACCESS_EN
    .MEM_size(size), .MEM_signed(sgn),
`endif
    .MEM_R_value(r_value), .freeze(freeze), .SRAM_DQ(dq), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n)
  );

  // 32-bit bus, zero wait states, read-only use
  logic [31:0]   alu32;
  logic          r32;
  wire  [31:0]   rv32;
  wire           frz32;
  wire  [31:0]   dq32;
  wire  [AW-1:0] addr32;
  wire           ub32, lb32, we32, ce32, oe32;

  mem_stage_sram #(.SRAM_DW(32), .SRAM_AW(AW), .WAIT_CYCLES(0)) u_dut32 (
    .clk(clk), .rst(rst), .ALU_result(alu32), .ST_val(32'h0),
    .MEM_R_en(r32), .MEM_W_en(1'b0),
`ifdef SUBWORD_ACCESS_EN
    .MEM_size(2'b10), .MEM_signed(1'b0),
`endif
    .MEM_R_value(rv32), .freeze(frz32), .SRAM_DQ(dq32), .SRAM_ADDR(addr32),
    .SRAM_UB_N(ub32), .SRAM_LB_N(lb32), .SRAM_WE_N(we32), .SRAM_CE_N(ce32),
    .SRAM_OE_N(oe32)
  );

  assign dq32 = (!ce32 && !oe32 && we32) ? ({14'h0, addr32} ^ 32'hA5A5_0000) : 32'hz;

  // Asynchronous SRAM model for the default DUT
  logic [DW-1:0]        sram [0:(1<<AW)-1];
  logic [AW+DW-1:0]     wr_log [$];
  int                   oe_cnt;
  logic [31:0]          ref_mem [int];
  logic [31:0]          last_load;
  int                   vectors = 0;
  int                   miscompares = 0;

  assign dq = (!ce_n && !oe_n && we_n) ? sram[addr] : {DW{1'bz}};

  always @(posedge clk) if (!ce_n && !we_n) sram[addr] <= dq;

  always @(negedge clk) begin
    if (!ce_n && !we_n) wr_log.push_back({addr, dq});
    if (!ce_n && !oe_n) oe_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The SRAM holds 2^AW half-words, i.e. 2^(AW-1) 32-bit words.
  function automatic int key(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << (AW - LOG_B)) - 1));
  endfunction

  function automatic logic [31:0] ref_rd(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd,
                           input int exp_cyc, input string tag);
    int n;
    int b;
    logic [31:0] ea;
    @(negedge clk);
    alu = a; st_val = d; w_en = wr; r_en = rd;
    wr_log.delete();
    oe_cnt = 0;
    #1;
    n = 0;
    while (freeze && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    check({tag, " freeze_cycles"}, 64'(n), 64'(exp_cyc));
    if (wr) begin
      check({tag, " write_entries"}, 64'(wr_log.size()), 64'(BEATS * (WC + 1)));
      for (int i = 0; i < wr_log.size() && i < BEATS * (WC + 1); i++) begin
        b  = i / (WC + 1);
        ea = (32'(key(a)) << LOG_B) | 32'(b);
        check({tag, " write_addr_data"}, 64'(wr_log[i]), 64'({ea[AW-1:0], d[DW*b +: DW]}));
      end
      check({tag, " oe_low_on_write"}, 64'(oe_cnt), 64'd0);
      check({tag, " rvalue_held"}, 64'(r_value), 64'(last_load));
      ref_mem[key(a)] = d;
    end else begin
      check({tag, " load_value"}, 64'(r_value), 64'(exp_rd));
      last_load = exp_rd;
    end
  endtask

  task automatic load32(input logic [31:0] a);
    int n;
    logic [AW-1:0] seen;
    @(negedge clk);
    alu32 = a; r32 = 1'b1;
    seen = '0;
    #1;
    n = 0;
    while (frz32 && n < 50) begin
      n++;
      @(negedge clk); #1;
      if (!ce32) seen = addr32;
    end
    check("dw32 freeze_cycles", 64'(n), 64'd2);
    check("dw32 sram_addr", 64'(seen), 64'(a[19:2]));
    check("dw32 load_value", 64'(rv32), 64'({14'h0, a[19:2]} ^ 32'hA5A5_0000));
    r32 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_r, d_r;
    int n, op;
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; alu = '0; st_val = '0;
    r32 = 1'b0; alu32 = '0;
    last_load = '0;
    oe_cnt = 0;
`ifdef SUBWORD_ACCESS_EN
    size = 2'b10; sgn = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) sram[i] = '0;

    #12;
    check("reset freeze", 64'(freeze), 64'd0);
    check("reset we_n", 64'(we_n), 64'd1);
    check("reset ce_n", 64'(ce_n), 64'd1);
    check("reset oe_n", 64'(oe_n), 64'd1);
    check("reset ub_lb", 64'({ub_n, lb_n}), 64'd0);
    check("reset r_value", 64'(r_value), 64'd0);
    check("reset dq_z", 64'(dq === {DW{1'bz}}), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed store then load at 0x100
    do_access(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 5, "store_100");
    do_access(1'b0, 1'b1, 32'h100, 32'h0, ref_rd(key(32'h100)), 5, "load_100");
    // Back-to-back with requests held: load then store
    do_access(1'b1, 1'b0, 32'h104, 32'h1234_5678, 32'h0, 5, "b2b_seed");
    do_access(1'b0, 1'b1, 32'h104, 32'h0, ref_rd(key(32'h104)), 5, "b2b_load");
    do_access(1'b1, 1'b0, 32'h108, 32'hCAFE_F00D, 32'h0, 5, "b2b_store");
    // Both enables: store wins
    do_access(1'b1, 1'b1, 32'h10C, 32'h0BAD_CAFE, 32'h0, 5, "both_en");
    do_access(1'b0, 1'b1, 32'h10C, 32'h0, ref_rd(key(32'h10C)), 5, "both_en_load");

    // Reset mid-write, request held across it
    @(negedge clk);
    alu = 32'h300; st_val = 32'h5555_AAAA; w_en = 1'b1; r_en = 1'b0;
    repeat (2) @(negedge clk);
    check("midwrite we_n_low", 64'(we_n), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst we_n", 64'(we_n), 64'd1);
    check("midrst dq_z", 64'(dq === {DW{1'bz}}), 64'd1);
    check("midrst ce_n", 64'(ce_n), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    last_load = '0;
    wr_log.delete();
    #1;
    check("postrst freeze", 64'(freeze), 64'd1);
    check("postrst idle_ce_n", 64'(ce_n), 64'd1);
    n = 0;
    while (freeze && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    check("postrst freeze_cycles", 64'(n), 64'd5);
    check("postrst write_entries", 64'(wr_log.size()), 64'(BEATS * (WC + 1)));
    check("postrst r_value", 64'(r_value), 64'd0);
    ref_mem[key(32'h300)] = 32'h5555_AAAA;
    do_access(1'b0, 1'b1, 32'h300, 32'h0, ref_rd(key(32'h300)), 5, "postrst_load");

    // Request withdrawn mid-access: the store still completes
    @(negedge clk);
    alu = 32'h304; st_val = 32'h7777_1111; w_en = 1'b1; r_en = 1'b0;
    wr_log.delete();
    repeat (2) @(negedge clk);
    w_en = 1'b0;
    #1;
    check("flush freeze_low", 64'(freeze), 64'd0);
    repeat (6) @(negedge clk);
    check("flush write_entries", 64'(wr_log.size()), 64'(BEATS * (WC + 1)));
    ref_mem[key(32'h304)] = 32'h7777_1111;
    do_access(1'b0, 1'b1, 32'h304, 32'h0, ref_rd(key(32'h304)), 5, "flush_load");

    // Randomized mix over a small word pool with random ignored upper bits
    for (int i = 0; i < 40; i++) begin
      a_r = ($urandom & 32'hFFF8_0000) | (32'($urandom_range(0, 15)) << 2);
      d_r = $urandom;
      op  = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        r_en = 1'b0; w_en = 1'b0;
      end
      do_access(op != 0, op != 1, a_r, d_r, ref_rd(key(a_r)), 5, "rand");
    end

`ifdef SUBWORD_ACCESS_EN
    do_access(1'b1, 1'b0, 32'h200, 32'h0000_0080, 32'h0, 5, "sub_store");
    size = 2'b00; sgn = 1'b1;
    do_access(1'b0, 1'b1, 32'h200, 32'h0, 32'hFFFF_FF80, 3, "sub_sbyte");
    size = 2'b10; sgn = 1'b0;
`endif

    @(negedge clk);
    r_en = 1'b0; w_en = 1'b0;
    for (int i = 0; i < 3; i++) load32($urandom & 32'h000F_FFFC);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
